// File: rtl/conv3x3_window_mac.sv
// 3x3 window convolution with bias, shift, ReLU and saturation, fed by the stride-1 line buffer.
// Kernel weights are loaded serially into a shadow bank and committed to the active bank in one cycle.
module conv3x3_window_mac #(
  parameter int input_y  = 6,
  parameter int input_x  = 6,
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int OUT_W    = 8,
  parameter int SHIFT    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sof,
  input  logic                  window_valid,
  input  logic [9*DATA_W-1:0]   window_data,
  input  logic                  w_load_start,
  input  logic                  w_valid,
  input  logic [WEIGHT_W-1:0]   w_data,
  output logic                  weights_ready,
  output logic                  out_valid,
  output logic [OUT_W-1:0]      out_data,
  output logic [10:0]           out_row,
  output logic [10:0]           out_col,
  output logic                  eof,
  output logic                  cfg_err,
  output logic                  frame_err
);
  localparam int PROD_W = DATA_W + WEIGHT_W + 1;
  localparam int ROW_W  = PROD_W + 2;
  localparam int ACC_W  = DATA_W + WEIGHT_W + 5;
  localparam logic [10:0] COL_LAST = 11'(input_y - 3);
  localparam logic [10:0] ROW_LAST = 11'(input_x - 3);
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((1 << OUT_W) - 1);

  // Handshake: window_valid has no back-pressure; a window is consumed in the cycle it is
  // presented if accepted, otherwise dropped and flagged. w_valid beats are likewise never stalled.

  typedef enum logic [0:0] {W_IDLE, W_LOAD} w_state_t;
  w_state_t w_state, w_state_next;

  logic [3:0] beat_cnt;
  logic       beat_clr, beat_wr, commit;
  logic signed [WEIGHT_W-1:0] shadow [10];
  logic signed [WEIGHT_W-1:0] k_act [9];
  logic signed [WEIGHT_W-1:0] bias_act;

  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_state_next;
  end

  always_comb begin
    w_state_next = w_state;
    beat_clr     = 1'b0;
    beat_wr      = 1'b0;
    commit       = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (w_load_start) begin
          w_state_next = W_LOAD;
          beat_clr     = 1'b1;
        end
      end
      W_LOAD: begin
        if (w_load_start) begin
          beat_clr = 1'b1;
        end else if (w_valid) begin
          beat_wr = 1'b1;
          if (beat_cnt == 4'd9) begin
            commit       = 1'b1;
            w_state_next = W_IDLE;
          end
        end
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  // The bias is the final beat, so it is taken straight from w_data at commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt      <= '0;
      weights_ready <= 1'b0;
      bias_act      <= '0;
      for (int i = 0; i < 10; i++) shadow[i] <= '0;
      for (int i = 0; i < 9; i++)  k_act[i]  <= '0;
    end else begin
      if (beat_clr) begin
        beat_cnt <= '0;
      end else if (beat_wr) begin
        shadow[beat_cnt] <= w_data;
        beat_cnt         <= beat_cnt + 4'd1;
      end
      if (commit) begin
        for (int i = 0; i < 9; i++) k_act[i] <= shadow[i];
        bias_act      <= w_data;
        weights_ready <= 1'b1;
      end
    end
  end

  logic [10:0] row_cnt, col_cnt;
  logic        frame_done, accept;

  assign accept = window_valid & weights_ready & ~sof & ~frame_done;

  always_ff @(posedge clk) begin
    if (rst || sof) begin
      row_cnt    <= '0;
      col_cnt    <= '0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (window_valid && !weights_ready) cfg_err <= 1'b1;
      if (window_valid && weights_ready && frame_done) frame_err <= 1'b1;
      if (accept) begin
        if (col_cnt == COL_LAST) begin
          col_cnt <= '0;
          if (row_cnt == ROW_LAST) begin
            row_cnt    <= '0;
            frame_done <= 1'b1;
          end else begin
            row_cnt <= row_cnt + 11'd1;
          end
        end else begin
          col_cnt <= col_cnt + 11'd1;
        end
      end
    end
  end

  logic v1, v2, v3;
  logic signed [PROD_W-1:0]   prod [9];
  logic signed [ROW_W-1:0]    rsum [3];
  logic signed [WEIGHT_W-1:0] bias1, bias2;
  logic signed [ACC_W-1:0]    acc, shifted;
  logic [10:0] row1, col1, row2, col2, row3, col3;
  logic        last1, last2, last3;
  logic [OUT_W-1:0] sat;

  always_ff @(posedge clk) begin
    if (rst || sof) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      v1 <= accept;
      v2 <= v1;
      v3 <= v2;
    end
  end

  // Bias travels with its window so a mid-frame commit never mixes old and new kernels.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < 9; i++)
        prod[i] <= PROD_W'($signed({1'b0, window_data[i*DATA_W +: DATA_W]})) * PROD_W'(k_act[i]);
      bias1 <= bias_act;
      row1  <= row_cnt;
      col1  <= col_cnt;
      last1 <= (row_cnt == ROW_LAST) && (col_cnt == COL_LAST);
    end
    if (v1) begin
      for (int r = 0; r < 3; r++)
        rsum[r] <= ROW_W'(prod[3*r]) + ROW_W'(prod[3*r+1]) + ROW_W'(prod[3*r+2]);
      bias2 <= bias1;
      row2  <= row1;
      col2  <= col1;
      last2 <= last1;
    end
    if (v2) begin
      acc   <= ACC_W'(rsum[0]) + ACC_W'(rsum[1]) + ACC_W'(rsum[2]) + ACC_W'(bias2);
      row3  <= row2;
      col3  <= col2;
      last3 <= last2;
    end
  end

  assign shifted = acc >>> SHIFT;

  always_comb begin
    sat = '0;
    if (shifted[ACC_W-1])       sat = '0;
    else if (shifted > OUT_MAX) sat = '1;
    else                        sat = shifted[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      eof       <= 1'b0;
    end else begin
      out_valid <= v3 & ~sof;
      eof       <= v3 & last3 & ~sof;
      if (v3 && !sof) begin
        out_data <= sat;
        out_row  <= row3;
        out_col  <= col3;
      end
    end
  end

endmodule

// File: doc/conv3x3_window_mac.md
Name: conv3x3_window_mac

Overview:
- Downstream consumer of the stride-1, no-padding 3x3 line buffer.
- Takes each valid 3x3 pixel window (9 pixels, flattened) and computes a signed 3x3 convolution plus bias.
- Applies arithmetic shift, ReLU and unsigned saturation, and emits one output pixel per window through a 4-stage pipeline.
- Tracks output row/column, flags end of frame, and double-buffers kernel weights loaded over a serial port.

Parameters:
- input_y, 6, input row width in pixels; output row width is input_y-2.
- input_x, 6, input frame height in rows; output height is input_x-2.
- DATA_W, 8, unsigned pixel width.
- WEIGHT_W, 8, signed weight/bias width (two's complement).
- OUT_W, 8, unsigned output pixel width.
- SHIFT, 0, arithmetic right shift applied to the accumulator before ReLU.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- sof  in  1  start-of-frame pulse, same signal that drives the line buffer control.
- window_valid  in  1  one window present on window_data (the line buffer control's output_valid).
- window_data  in  9*DATA_W  pixels p0..p8, p0 in the LSBs; row-major, p0 = top-left, p8 = bottom-right.
- w_load_start  in  1  begin serial load of a new kernel.
- w_valid  in  1  w_data beat valid.
- w_data  in  WEIGHT_W  weight beat: beats 0-8 are k0..k8 (row-major), beat 9 is bias.
- weights_ready  out  1  an active kernel has been committed.
- out_valid  out  1  out_data valid.
- out_data  out  OUT_W  result pixel.
- out_row  out  11  output row index of out_data.
- out_col  out  11  output column index of out_data.
- eof  out  1  asserted with the last output of the frame.
- cfg_err  out  1  sticky: a window arrived while weights_ready=0.
- frame_err  out  1  sticky: a window arrived after the frame's last window.

Behaviour:
- Reset: all outputs are 0, active and shadow weights are 0, counters are 0, load FSM is W_IDLE.
- Load FSM states:
  - W_IDLE: w_load_start -> W_LOAD with beat_cnt=0. w_valid in W_IDLE is ignored.
  - W_LOAD: each w_valid writes w_data to shadow[beat_cnt] and increments beat_cnt.
  - On beat 9, the FSM copies shadow to active (all 10 values in one cycle) and returns to W_IDLE.
  - weights_ready goes to 1 the cycle after the commit and stays 1 until rst.
  - w_load_start while in W_LOAD restarts at beat_cnt=0 and discards the partial shadow.
  - Active weights stay in use during a reload. Windows accepted at or before the commit cycle use the old kernel; windows from the next cycle use the new kernel.
- Accept condition: window_valid & weights_ready & !sof & (frame not complete).
  - window_valid with weights_ready=0 sets cfg_err and produces no output.
  - window_valid after the last window sets frame_err and produces no output.
- Pipeline stages (latency 4: window accepted at cycle t gives out_valid at t+4; fully pipelined, one window per cycle):
  - S1: 9 products, each {1'b0,p_i} (signed) * k_i, DATA_W+WEIGHT_W+1 bits.
  - S2: 3 row sums of 3 products.
  - S3: sum of row sums plus sign-extended bias. ACC_W = DATA_W+WEIGHT_W+5, which cannot overflow.
  - S4: arithmetic shift right by SHIFT; negative -> 0; value > 2^OUT_W-1 -> 2^OUT_W-1; else low OUT_W bits. out_data holds its last value when out_valid=0.
- Coordinates are captured at accept and travel with the pipeline.
  - col runs 0..input_y-3; at wrap, col returns to 0 and row increments.
  - The last window is row=input_x-3, col=input_y-3. eof=1 on that output only, and the frame is then complete.
  - Outputs per frame = (input_x-2)*(input_y-2).
- sof handling:
  - Clears row/col and the frame-complete flag.
  - Clears frame_err and cfg_err.
  - Clears all pipeline valid bits, so in-flight results are dropped and out_valid=0 for the next 4 cycles unless new windows arrive.
  - window_valid in the sof cycle is discarded.
  - sof does not affect weights or the load FSM.
- rst mid-frame or mid-load returns to the reset state and clears weights_ready.

Test Plan:
- Weights all 1, bias 0, input_x=input_y=6; 16 windows of all-10 pixels -> 16 out_valid pulses, each out_data=90 exactly 4 cycles after its window; coordinates (0,0)..(3,3); eof only on the 16th.
- Saturation and ReLU: weights all 127, pixels 255 -> out_data=255. Weights all -1, bias 5, pixels 1 -> out_data=0. SHIFT=2, weights 1, pixels 4, bias 0 -> 9.
- Window before any load -> no out_valid, cfg_err=1. Complete load -> weights_ready=1 one cycle after beat 9. Next sof -> cfg_err=0.
- sof asserted while 2 windows are in flight -> neither produces out_valid; next window yields out_row=0, out_col=0.
- 17th window in a 6x6 frame -> dropped, frame_err=1, no second eof.
- Reload mid-frame from weights 1 to weights 2 (pixels 1) -> outputs are 9 up to the commit-cycle window and 18 from the next window, with no gap in out_valid.
